ext_event_timer: RTL and testbench
==================================

// Module: ext_event_timer
// PURPOSE
//  Counts single-cycle event strobes from the input edge detector (its selected-edge strobe output).
//  Events pass through a programmable prescaler into an up-counter with auto-reload.
//  Block produces a wrap/match pulse, a sticky overflow flag and the live count.
//  Sits directly downstream of the edge detector, in the clk_i domain, inside the timer core.
// PARAMETERS
//  CNT_W  16  counter / auto-reload width
//  PSC_W  8   prescaler width; divide ratio = psc_i+1
// PORTS
//  clk_i       in   1      system clock; sole clock, all logic on posedge
//  rst_i       in   1      reset, asynchronous, active-high
//  en_i        in   1      run enable; 0 = hold all state (prescaler and counter)
//  mode_i      in   1      0 = continuous auto-reload, 1 = one-shot
//  clr_i       in   1      sync clear: prescaler, counter, FSM to IDLE
//  event_i     in   1      single-cycle event strobe from edge detector
//  psc_i       in   PSC_W  prescale value; one tick every psc_i+1 events
//  arr_i       in   CNT_W  auto-reload top; counter wraps after reaching arr_i
//  flag_clr_i  in   1      clears ovf_flag_o
//  cnt_o       out  CNT_W  current count
//  match_o     out  1      1-cycle pulse on wrap (arr_i -> 0)
//  ovf_flag_o  out  1      sticky wrap flag
//  busy_o      out  1      1 while FSM in RUN
// BEHAVIOUR
//  Reset: cnt_o=0, prescaler=0, match_o=0, ovf_flag_o=0, busy_o=0, FSM=IDLE.
//  FSM states: IDLE, RUN, DONE.
//   IDLE->RUN when en_i=1; RUN->IDLE when en_i=0 (count held, not cleared).
//   RUN->DONE on wrap when mode_i=1; DONE holds cnt_o=0 until clr_i; DONE ignores events.
//   clr_i from any state -> IDLE; clr_i has priority over event_i the same cycle.
//  Events are counted only in RUN. event_i with en_i=0 or in IDLE/DONE is dropped.
//  Prescaler: on each counted event, psc_cnt == psc_i ? (psc_cnt<=0, tick) : psc_cnt+1.
//   psc_i=0 -> every event ticks. psc_i lowered below psc_cnt -> next event ticks.
//  Counter on tick: cnt_o >= arr_i ? (cnt_o<=0, wrap) : cnt_o+1.
//   The >= compare covers arr_i lowered mid-run; arr_i=0 -> every tick wraps, cnt_o stays 0.
//   All-ones arr_i must not wrap arithmetically before the compare.
//  Latency: event_i at cycle n -> cnt_o/match_o updated at n+1 (registered). No combinational path.
//  match_o: high exactly the cycle cnt_o first shows 0 after a wrap; never 2 consecutive cycles.
//   Exception: arr_i=0 with back-to-back ticks.
//  ovf_flag_o: set on wrap, cleared by flag_clr_i; set wins if both occur the same cycle.
//   Not cleared by clr_i.
//  Async rst_i mid-count returns all outputs to reset values immediately; no events are retained.
// CONFIGURATION
//  EXT_TIMER_CAPTURE_EN defined: adds ports cap_i (in,1), cap_o (out,CNT_W), cap_valid_o (out,1).
//   cap_i=1 -> cap_o<=cnt_o (pre-update value) at the next edge; cap_valid_o=1.
//   cap_valid_o clears on flag_clr_i; cap_i wins if both. Reset: cap_o=0, cap_valid_o=0.
//  Macro undefined: capture ports and registers are absent; all other behaviour is identical.
// TESTING
//  1 rst_i=1 async mid-cycle, then release -> all outputs 0, FSM IDLE, busy_o=0.
//  2 psc_i=0, arr_i=3, mode_i=0, en_i=1, 9 events ->
//    cnt_o 1,2,3,0,1,2,3,0,1; match_o after events 4 and 8; ovf_flag_o=1.
//  3 psc_i=2, arr_i=5, 6 events -> cnt_o=2; no match_o.
//  4 mode_i=1, arr_i=2, 5 events -> match_o once at event 3; busy_o=0; cnt_o stays 0;
//    after clr_i then en_i=1 -> busy_o=1.
//  5 clr_i and event_i same cycle with cnt_o=4 -> cnt_o=0, no increment.
//    flag_clr_i together with a wrap -> ovf_flag_o remains 1.
//  6 cnt_o=7, arr_i changed to 3, one event -> cnt_o=0 and match_o=1.
//    With EXT_TIMER_CAPTURE_EN: cap_i at cnt_o=2 -> cap_o=2, cap_valid_o=1.

Source files
------------

// File: rtl/ext_event_timer.sv
// Event-driven timer: prescaled up-counter with auto-reload, wrap pulse and sticky overflow flag.
// Optional capture register enabled by defining EXT_TIMER_CAPTURE_EN.
module ext_event_timer #(
   parameter int CNT_W = 16,
   parameter int PSC_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             mode_i,
   input  logic             clr_i,
   input  logic             event_i,
   input  logic [PSC_W-1:0] psc_i,
   input  logic [CNT_W-1:0] arr_i,
   input  logic             flag_clr_i,
`ifdef EXT_TIMER_CAPTURE_EN
   input  logic             cap_i,
   output logic [CNT_W-1:0] cap_o,
   output logic             cap_valid_o,
`endif
   output logic [CNT_W-1:0] cnt_o,
   output logic             match_o,
   output logic             ovf_flag_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [PSC_W-1:0] PSC_ONE = 1;

   state_t           state;
   logic [PSC_W-1:0] psc_cnt;
   logic             count_ev;
   logic             tick;
   logic             wrap;

   // The >= compares keep working when psc_i/arr_i are lowered below the live
   // values, and the counter only increments below arr_i so it never overflows.
   always_comb begin
      count_ev = 1'b0;
      tick     = 1'b0;
      wrap     = 1'b0;
      count_ev = (state == RUN) && en_i && event_i && !clr_i;
      tick     = count_ev && (psc_cnt >= psc_i);
      wrap     = tick && (cnt_o >= arr_i);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         busy_o  <= 1'b0;
         psc_cnt <= '0;
         cnt_o   <= '0;
         match_o <= 1'b0;
      end else begin
         match_o <= wrap;
         if (clr_i) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            psc_cnt <= '0;
            cnt_o   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (en_i) begin
                     state  <= RUN;
                     busy_o <= 1'b1;
                  end
               end
               RUN: begin
                  if (!en_i) begin
                     state  <= IDLE;
                     busy_o <= 1'b0;
                  end else if (count_ev) begin
                     if (tick) begin
                        psc_cnt <= '0;
                        if (wrap) begin
                           cnt_o <= '0;
                           if (mode_i) begin
                              state  <= DONE;
                              busy_o <= 1'b0;
                           end
                        end else begin
                           cnt_o <= cnt_o + CNT_ONE;
                        end
                     end else begin
                        psc_cnt <= psc_cnt + PSC_ONE;
                     end
                  end
               end
               DONE: begin
                  cnt_o <= '0;
               end
               default: begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            endcase
         end
      end
   end

   // A wrap in the same cycle as flag_clr_i must leave the flag set.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_flag_o <= 1'b0;
      end else if (wrap) begin
         ovf_flag_o <= 1'b1;
      end else if (flag_clr_i) begin
         ovf_flag_o <= 1'b0;
      end
   end

`ifdef EXT_TIMER_CAPTURE_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cap_o       <= '0;
         cap_valid_o <= 1'b0;
      end else if (cap_i) begin
         cap_o       <= cnt_o;
         cap_valid_o <= 1'b1;
      end else if (flag_clr_i) begin
         cap_valid_o <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_ext_event_timer.sv
// Directed self-checking bench for ext_event_timer; inputs change and outputs are sampled on negedge.
module tb_ext_event_timer;

   localparam int CNT_W = 16;
   localparam int PSC_W = 8;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             en_i = 1'b0;
   logic             mode_i = 1'b0;
   logic             clr_i = 1'b0;
   logic             event_i = 1'b0;
   logic [PSC_W-1:0] psc_i = '0;
   logic [CNT_W-1:0] arr_i = '0;
   logic             flag_clr_i = 1'b0;
   logic             cap_i = 1'b0;
   logic [CNT_W-1:0] cnt_o;
   logic             match_o;
   logic             ovf_flag_o;
   logic             busy_o;
`ifdef EXT_TIMER_CAPTURE_EN
   logic [CNT_W-1:0] cap_o;
   logic             cap_valid_o;
`endif

   int checks = 0;
   int errors = 0;
   int matchCount;
   int exp2[9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};

   always #5 clk_i = ~clk_i;

   ext_event_timer #(.CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .en_i(en_i),
      .mode_i(mode_i),
      .clr_i(clr_i),
      .event_i(event_i),
      .psc_i(psc_i),
      .arr_i(arr_i),
      .flag_clr_i(flag_clr_i),
`ifdef EXT_TIMER_CAPTURE_EN
      .cap_i(cap_i),
      .cap_o(cap_o),
      .cap_valid_o(cap_valid_o),
`endif
      .cnt_o(cnt_o),
      .match_o(match_o),
      .ovf_flag_o(ovf_flag_o),
      .busy_o(busy_o)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Holds the strobes for one clock, starting and ending on a negedge.
   task automatic applyStimulus(input logic ev, input logic clr, input logic fclr, input logic cap);
      event_i    = ev;
      clr_i      = clr;
      flag_clr_i = fclr;
      cap_i      = cap;
      @(negedge clk_i);
      event_i    = 1'b0;
      clr_i      = 1'b0;
      flag_clr_i = 1'b0;
      cap_i      = 1'b0;
   endtask

   initial begin
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("rst_cnt", cnt_o, 0);
      checkOutput("rst_match", match_o, 0);
      checkOutput("rst_ovf", ovf_flag_o, 0);
      checkOutput("rst_busy", busy_o, 0);

      // Continuous mode, no prescale, wrap every 4 events
      psc_i  = 8'd0;
      arr_i  = 16'd3;
      mode_i = 1'b0;
      en_i   = 1'b1;
      applyStimulus(0, 0, 0, 0);
      checkOutput("t2_busy", busy_o, 1);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1, 0, 0, 0);
         checkOutput($sformatf("t2_cnt%0d", i), cnt_o, exp2[i]);
         checkOutput($sformatf("t2_match%0d", i), match_o, (i == 3 || i == 7) ? 1 : 0);
      end
      checkOutput("t2_ovf", ovf_flag_o, 1);

      // Asynchronous reset in the middle of a cycle
      #2 rst_i = 1'b1;
      #1;
      checkOutput("t1_cnt", cnt_o, 0);
      checkOutput("t1_ovf", ovf_flag_o, 0);
      checkOutput("t1_busy", busy_o, 0);
      checkOutput("t1_match", match_o, 0);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("t1_rerun_busy", busy_o, 1);
      checkOutput("t1_rerun_cnt", cnt_o, 0);

      // Prescale by 3: six events give two ticks
      psc_i = 8'd2;
      arr_i = 16'd5;
      matchCount = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, 0, 0, 0);
         if (match_o) matchCount++;
         if (i == 2) checkOutput("t3_cnt_mid", cnt_o, 1);
      end
      checkOutput("t3_cnt", cnt_o, 2);
      checkOutput("t3_nomatch", matchCount, 0);

      // One-shot: stops in DONE after the first wrap
      psc_i  = 8'd0;
      arr_i  = 16'd2;
      mode_i = 1'b1;
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("t4_busy_start", busy_o, 1);
      matchCount = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 0, 0);
         if (match_o) matchCount++;
         if (i == 2) checkOutput("t4_match_at3", match_o, 1);
      end
      checkOutput("t4_match_once", matchCount, 1);
      checkOutput("t4_busy_done", busy_o, 0);
      checkOutput("t4_cnt", cnt_o, 0);
      checkOutput("t4_ovf", ovf_flag_o, 1);
      applyStimulus(0, 1, 0, 0);
      checkOutput("t4_busy_clr", busy_o, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("t4_busy_rerun", busy_o, 1);

      // Clear beats a same-cycle event; flag survives clr_i
      mode_i = 1'b0;
      arr_i  = 16'd10;
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0);
      checkOutput("t5_cnt4", cnt_o, 4);
      applyStimulus(1, 1, 0, 0);
      checkOutput("t5_clr_cnt", cnt_o, 0);
      checkOutput("t5_clr_busy", busy_o, 0);
      checkOutput("t5_clr_keep_ovf", ovf_flag_o, 1);
      applyStimulus(0, 0, 0, 0);
      arr_i = 16'd0;
      applyStimulus(0, 0, 1, 0);
      checkOutput("t5_fclr", ovf_flag_o, 0);
      applyStimulus(1, 0, 1, 0);
      checkOutput("t5_set_wins", ovf_flag_o, 1);
      checkOutput("t5_arr0_match", match_o, 1);
      checkOutput("t5_arr0_cnt", cnt_o, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("t5_match_pulse", match_o, 0);

      // Lowering arr_i below the live count wraps on the next tick
      arr_i = 16'd10;
      for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 0);
      checkOutput("t6_cnt7", cnt_o, 7);
      arr_i = 16'd3;
      applyStimulus(1, 0, 0, 0);
      checkOutput("t6_cnt", cnt_o, 0);
      checkOutput("t6_match", match_o, 1);

      arr_i = 16'd10;
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("t6_cnt2", cnt_o, 2);
`ifdef EXT_TIMER_CAPTURE_EN
      applyStimulus(0, 0, 0, 1);
      checkOutput("cap_val", cap_o, 2);
      checkOutput("cap_valid", cap_valid_o, 1);
      applyStimulus(0, 0, 1, 0);
      checkOutput("cap_valid_clr", cap_valid_o, 0);
      applyStimulus(0, 0, 1, 1);
      checkOutput("cap_wins", cap_valid_o, 1);
      checkOutput("cap_val2", cap_o, 2);
`endif

      // Disabled: events dropped, count held
      en_i = 1'b0;
      applyStimulus(0, 0, 0, 0);
      checkOutput("hold_busy", busy_o, 0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("hold_cnt", cnt_o, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
